// File: rtl/mod_time_counter_pkg.sv
// rtl/mod_time_counter_pkg.sv - shared constants and width helper for the time-digit counters
package mod_time_counter_pkg;

    localparam int TIME_SEC_MOD = 60;
    localparam int TIME_MIN_MOD = 60;
    localparam int TIME_HR_MOD  = 24;

    // 7-seg codes, bit order gfedcba, segment on = 1
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // bits needed to hold 0..modulo-1
    function automatic int count_width(input int modulo);
        int w;
        w = 1;
        while ((1 << w) < modulo) w++;
        return w;
    endfunction

endpackage

// File: rtl/mod_time_counter_if.sv
// rtl/mod_time_counter_if.sv - control and digit signals of one time-counter stage
interface mod_time_counter_if #(
    parameter int WIDTH = 7
);
    logic             tick_in;
    logic             hold;
    logic             adj_n;
    logic             adj_up;
    logic [WIDTH-1:0] count;
    logic [3:0]       bcd_tens;
    logic [3:0]       bcd_ones;
    logic             carry_out;

    modport master (
        output tick_in, hold, adj_n, adj_up,
        input  count, bcd_tens, bcd_ones, carry_out
    );

    modport slave (
        input  tick_in, hold, adj_n, adj_up,
        output count, bcd_tens, bcd_ones, carry_out
    );
endinterface

// File: rtl/bcd_digit_split.sv
// rtl/bcd_digit_split.sv - combinational split of a 0..99 count into tens and ones digits
module bcd_digit_split #(
    parameter int WIDTH = 7
) (
    input  logic [WIDTH-1:0] count,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones
);
    logic [6:0] value;

    assign value    = 7'(count);
    assign bcd_tens = 4'(value / 7'd10);
    assign bcd_ones = 4'(value % 7'd10);
endmodule

// File: rtl/mod_time_counter.sv
// rtl/mod_time_counter.sv - modulo-N time digit with carry chaining and manual adjust; ADJ_REPEAT_EN adds auto-repeat
module mod_time_counter
    import mod_time_counter_pkg::*;
#(
    parameter int MODULO        = TIME_SEC_MOD,
    parameter int WIDTH         = 7,
    parameter int RESET_VAL     = 0,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic              clk50,
    input  logic              reset,
    mod_time_counter_if.slave bus
);
    if (MODULO < 2 || MODULO > 100) begin : g_bad_modulo
        $fatal(1, "mod_time_counter: MODULO must be 2..100");
    end
    if (WIDTH < count_width(MODULO)) begin : g_bad_width
        $fatal(1, "mod_time_counter: WIDTH too small for MODULO");
    end
    if (RESET_VAL < 0 || RESET_VAL >= MODULO) begin : g_bad_reset_val
        $fatal(1, "mod_time_counter: RESET_VAL must be below MODULO");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $fatal(1, "mod_time_counter: repeat timing must be at least one cycle");
    end

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] count_dec;
    logic             carry_q;
    logic             tick_q;
    logic             adj_q;
    logic             tick_rise;
    logic             adj_fall;
    logic             rep_fire;
    logic             adj_step;
    logic             tick_step;
    logic [3:0]       tens;
    logic [3:0]       ones;

    assign tick_rise = bus.tick_in & ~tick_q;
    assign adj_fall  = ~bus.adj_n & adj_q;

`ifdef ADJ_REPEAT_EN
    // Zero means idle; a fall loads the delay and the step fires when it counts down to one.
    logic [31:0] rep_cnt;

    assign rep_fire = ~bus.adj_n & ~adj_q & (rep_cnt == 32'd1);

    always_ff @(posedge clk50) begin
        if (reset || bus.adj_n) begin
            rep_cnt <= '0;
        end else if (adj_fall) begin
            rep_cnt <= 32'(REPEAT_DELAY);
        end else if (rep_fire) begin
            rep_cnt <= 32'(REPEAT_PERIOD);
        end else if (rep_cnt != 32'd0) begin
            rep_cnt <= rep_cnt - 32'd1;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign adj_step  = adj_fall | rep_fire;
    assign tick_step = tick_rise & ~bus.hold & ~adj_step;
    assign count_inc = (count_q == MAX_VAL) ? '0 : count_q + WIDTH'(1);
    assign count_dec = (count_q == '0) ? MAX_VAL : count_q - WIDTH'(1);

    // adj_q follows the pin during reset so a button already held is not taken as a press
    always_ff @(posedge clk50) begin
        if (reset) begin
            count_q <= WIDTH'(RESET_VAL);
            carry_q <= 1'b0;
            tick_q  <= 1'b1;
            adj_q   <= bus.adj_n;
        end else begin
            tick_q  <= bus.tick_in;
            adj_q   <= bus.adj_n;
            carry_q <= tick_step & (count_q == MAX_VAL);
            if (adj_step) begin
                count_q <= bus.adj_up ? count_inc : count_dec;
            end else if (tick_step) begin
                count_q <= count_inc;
            end
        end
    end

    bcd_digit_split #(
        .WIDTH(WIDTH)
    ) u_split (
        .count    (count_q),
        .bcd_tens (tens),
        .bcd_ones (ones)
    );

    assign bus.count     = count_q;
    assign bus.carry_out = carry_q;
    assign bus.bcd_tens  = tens;
    assign bus.bcd_ones  = ones;
endmodule

// File: tb/tb_mod_time_counter.sv
// tb/tb_mod_time_counter.sv - self-checking bench for mod_time_counter against a behavioural model
module tb_mod_time_counter;
`ifdef ADJ_REPEAT_EN
    localparam int MOD = 24;
    localparam int RD  = 4;
    localparam int RP  = 2;
    localparam int T59 = 2;
    localparam int O59 = 3;
`else
    localparam int MOD = 60;
    localparam int RD  = 25_000_000;
    localparam int RP  = 5_000_000;
    localparam int T59 = 5;
    localparam int O59 = 9;
`endif
    localparam int RV = 0;

    logic clk50;
    logic reset;
    int   chk;
    int   err;
    bit   chk_en;

    int   m_count;
    int   m_carry;
    bit   m_tick_prev;
    bit   m_adj_prev;
    bit   m_valid;
    int   m_k;

    mod_time_counter_if #(.WIDTH(7)) bus ();

    mod_time_counter #(
        .MODULO        (MOD),
        .WIDTH         (7),
        .RESET_VAL     (RV),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk50 (clk50),
        .reset (reset),
        .bus   (bus)
    );

    initial clk50 = 1'b0;
    always #10 clk50 = ~clk50;

    task automatic check(input string name, input int act, input int exp);
        chk++;
        if (act != exp) begin
            err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: arithmetic on an integer count, cycles-since-press for auto-repeat.
    always @(posedge clk50) begin
        bit fall, rise, rep;
        if (reset) begin
            m_count     = RV;
            m_carry     = 0;
            m_tick_prev = 1'b1;
            m_adj_prev  = bus.adj_n;
            m_valid     = 1'b0;
            m_k         = 0;
        end else begin
            fall = !bus.adj_n && m_adj_prev;
            rise = bus.tick_in && !m_tick_prev;
            rep  = 1'b0;
`ifdef ADJ_REPEAT_EN
            if (fall) begin
                m_valid = 1'b1;
                m_k     = 0;
            end else if (!bus.adj_n && m_valid) begin
                m_k++;
                rep = (m_k >= RD) && (((m_k - RD) % RP) == 0);
            end else begin
                m_valid = 1'b0;
            end
`endif
            m_carry = 0;
            if (fall || rep) begin
                m_count = bus.adj_up ? (m_count + 1) % MOD : (m_count + MOD - 1) % MOD;
            end else if (rise && !bus.hold) begin
                if (m_count == MOD - 1) begin
                    m_count = 0;
                    m_carry = 1;
                end else begin
                    m_count = m_count + 1;
                end
            end
            m_tick_prev = bus.tick_in;
            m_adj_prev  = bus.adj_n;
        end
    end

    always @(negedge clk50) begin
        if (chk_en) begin
            check("count", int'(bus.count), m_count);
            check("carry_out", int'(bus.carry_out), m_carry);
            check("bcd_tens", int'(bus.bcd_tens), m_count / 10);
            check("bcd_ones", int'(bus.bcd_ones), m_count % 10);
        end
    end

    task automatic drive(input logic r, input logic t, input logic h, input logic a, input logic u);
        reset       = r;
        bus.tick_in = t;
        bus.hold    = h;
        bus.adj_n   = a;
        bus.adj_up  = u;
        @(negedge clk50);
    endtask

    initial begin
        logic t, h, a, u, r;
        chk    = 0;
        err    = 0;
        chk_en = 1'b0;
        reset  = 1'b1;
        bus.tick_in = 1'b1;
        bus.hold    = 1'b0;
        bus.adj_n   = 1'b0;
        bus.adj_up  = 1'b0;
        @(negedge clk50);

        // reset with tick high and button held: no step after release
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 0);
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 0);
            check("rel_count", int'(bus.count), 0);
            check("rel_carry", int'(bus.carry_out), 0);
        end
        drive(0, 0, 0, 1, 0);

        // adjust wraps both ways without carry
        drive(0, 0, 0, 0, 0);
        check("adj_dn_wrap", int'(bus.count), MOD - 1);
        check("adj_dn_carry", int'(bus.carry_out), 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1);
        check("adj_up_wrap", int'(bus.count), 0);
        check("adj_up_carry", int'(bus.carry_out), 0);
        drive(0, 0, 0, 1, 1);

        // two down presses to MOD-2, then ticks through the wrap
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        check("pre_wrap", int'(bus.count), MOD - 2);
        drive(0, 1, 0, 1, 0);
        check("at_max", int'(bus.count), MOD - 1);
        check("max_tens", int'(bus.bcd_tens), T59);
        check("max_ones", int'(bus.bcd_ones), O59);
        drive(0, 0, 0, 1, 0);
        drive(0, 1, 0, 1, 0);
        check("wrap_count", int'(bus.count), 0);
        check("wrap_carry", int'(bus.carry_out), 1);
        check("wrap_tens", int'(bus.bcd_tens), 0);
        check("wrap_ones", int'(bus.bcd_ones), 0);
        drive(0, 1, 0, 1, 0);
        check("carry_one_cycle", int'(bus.carry_out), 0);

        // hold blocks ticks, counting resumes afterwards
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 1, 0);
            drive(0, 1, 1, 1, 0);
        end
        check("hold_count", int'(bus.count), 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 1, 0, 1, 0);
        check("resume_count", int'(bus.count), 1);

        // adjust and tick in the same cycle: tick dropped
        for (int i = 0; i < 9; i++) begin
            drive(0, 0, 0, 1, 0);
            drive(0, 1, 0, 1, 0);
        end
        check("at_ten", int'(bus.count), 10);
        drive(0, 0, 0, 1, 0);
        drive(0, 1, 0, 0, 0);
        check("collide", int'(bus.count), 9);
        drive(0, 0, 0, 1, 0);
        check("collide_after", int'(bus.count), 9);

`ifdef ADJ_REPEAT_EN
        begin
            int exp6 [9];
            exp6 = '{23, 23, 23, 23, 0, 0, 1, 1, 2};
            drive(1, 0, 0, 1, 0);
            drive(0, 0, 0, 1, 0);
            drive(0, 0, 0, 0, 0);
            drive(0, 0, 0, 1, 0);
            drive(0, 0, 0, 0, 0);
            drive(0, 0, 0, 1, 0);
            check("rep_start", int'(bus.count), 22);
            for (int k = 0; k < 9; k++) begin
                drive(0, 0, 0, 0, 1);
                check("rep_count", int'(bus.count), exp6[k]);
                check("rep_carry", int'(bus.carry_out), 0);
            end
            drive(0, 0, 0, 1, 1);
        end
`endif

        // randomized traffic against the model
        t = bus.tick_in;
        h = 1'b0;
        a = 1'b1;
        u = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            r = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 2) == 0) t = ~t;
            if ($urandom_range(0, 19) == 0) h = ~h;
            if (a) begin
                if ($urandom_range(0, 7) == 0) begin
                    a = 1'b0;
                    u = 1'($urandom_range(0, 1));
                end
            end else if ($urandom_range(0, 5) == 0) begin
                a = 1'b1;
            end
            drive(r, t, h, a, u);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end
endmodule
